// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Reset vector, exception codes, queue entry layout and FSM states.
package inst_fetch_queue_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] IFQ_RESET_PC = 32'hBFC0_0000;
  localparam logic [4:0]  EXC_NONE     = 5'h00;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ERR_WAIT,
    ST_ERR_IDLE
  } ifq_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
    logic              exc;
  } ifq_entry_t;

  function automatic logic misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// ifq_fifo: synchronous W x D FIFO with flush.
// Push on a full FIFO is accepted only together with a pop.
module ifq_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(D+1)-1:0] cnt_o
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(D));
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push) wr_q <= nxt(wr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: PC generation, in-flight tags, decoupling queue.
// Optional IFQ_PERF_CNT_EN adds saturating stall/flush counters.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_req,
  output logic [31:0]       inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              exc_o,
  output logic [4:0]        exccode_o
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(DEPTH + 1);
  localparam int EW = $bits(ifq_entry_t);

  ifq_state_e    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] disc_q, disc_d;

  logic          acc, dok, keep;
  logic [31:0]   tag_dout;
  logic          q_push, q_pop, q_empty, q_full;
  logic [QW-1:0] q_cnt;
  ifq_entry_t    q_din, q_head;

  assign inst_addr = pc_q;
  assign inst_req  = resetn && state_q == ST_RUN
                  && int'(out_q) < MAX_OUT
                  && int'(out_q) + int'(q_cnt) < DEPTH
                  && !redirect_valid;

  assign acc   = inst_req & inst_addr_ok;
  // A response with nothing outstanding belongs to a pre-reset request.
  assign dok   = inst_data_ok & (out_q != '0);
  assign keep  = dok & (disc_q == '0);
  assign q_pop = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = acc ? pc_q + 32'd4 : pc_q;
    out_d   = out_q + OW'(acc) - OW'(dok);
    disc_d  = (dok && disc_q != '0) ? disc_q - OW'(1) : disc_q;
    q_push  = keep;
    q_din   = '{pc: tag_dout, inst: inst_rdata, exc: 1'b0};
    unique case (state_q)
      ST_ERR_WAIT: begin
        if (disc_q == '0) begin
          q_push  = 1'b1;
          q_din   = '{pc: pc_q, inst: '0, exc: 1'b1};
          state_d = ST_ERR_IDLE;
        end
      end
      default: ;
    endcase
    if (redirect_valid) begin
      q_push  = 1'b0;
      pc_d    = redirect_pc;
      disc_d  = out_d;
      state_d = misaligned(redirect_pc) ? ST_ERR_WAIT : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  ifq_fifo #(.W(32), .D(MAX_OUT)) u_tag (
    .clk    (clk),
    .rst_n  (resetn),
    .clr_i  (redirect_valid),
    .push_i (acc),
    .din_i  (pc_q),
    .pop_i  (keep),
    .dout_o (tag_dout),
    .empty_o(),
    .full_o (),
    .cnt_o  ()
  );

  ifq_fifo #(.W(EW), .D(DEPTH)) u_queue (
    .clk    (clk),
    .rst_n  (resetn),
    .clr_i  (redirect_valid),
    .push_i (q_push),
    .din_i  (q_din),
    .pop_i  (q_pop),
    .dout_o (q_head),
    .empty_o(q_empty),
    .full_o (q_full),
    .cnt_o  (q_cnt)
  );

  assign valid_o   = ~q_empty;
  assign pc_o      = valid_o ? q_head.pc : '0;
  assign inst_o    = valid_o ? q_head.inst : '0;
  assign exc_o     = valid_o & q_head.exc;
  assign exccode_o = exc_o ? EXC_ADEL : EXC_NONE;

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(q_push && q_full && !q_pop));

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!valid_o && ready_i && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (redirect_valid && flush_q != '1)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Random-stimulus bench for inst_fetch_queue with a stream-level model.
// Memory answers in order; data word is a hash of the fetch address.
module tb_inst_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        exc_o;
  logic [4:0]  exccode_o;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  inst_fetch_queue #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .exc_o         (exc_o),
    .exccode_o     (exccode_o)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        pend[$];
  int          cyc, ep, checks, errors;
  logic [31:0] m_fpc, m_exp_pc;
  int          m_occ;
  bit          m_err_mode, m_err_pend;
  bit          aok_rand;
  int          lat_min, lat_max, rdy_mode;
  int          flush_n, stall_n, pop_cnt;
  bit          last_dok;
  logic [31:0] lp_pc, lp_inst;
  logic        lp_exc;
  logic [4:0]  lp_code;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    ep++;
    m_fpc      = RST_PC;
    m_exp_pc   = RST_PC;
    m_occ      = 0;
    m_err_mode = 0;
    m_err_pend = 0;
    flush_n    = 0;
    stall_n    = 0;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc);
    bit exp_req, pop, keep, epush;
    @(negedge clk);
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_addr_ok   = aok_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(pend[0].addr);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom();
    end
    case (rdy_mode)
      0:       ready_i = 1'b1;
      2:       ready_i = 1'b0;
      default: ready_i = 1'($urandom_range(0, 1));
    endcase
    last_dok = inst_data_ok;
    #1;
    exp_req = !m_err_mode && pend.size() < MAX_OUT
           && pend.size() + m_occ < DEPTH && !redir;
    chk("inst_req", 32'(inst_req), 32'(exp_req));
    if (inst_req) chk("inst_addr", inst_addr, m_fpc);
    chk("valid_o", 32'(valid_o), 32'(m_occ > 0));
    pop = (m_occ > 0) && ready_i;
    if (pop) begin
      pop_cnt++;
      lp_pc   = pc_o;
      lp_inst = inst_o;
      lp_exc  = exc_o;
      lp_code = exccode_o;
      chk("pop_pc", pc_o, m_exp_pc);
      if (m_err_mode) begin
        chk("pop_exc", 32'(exc_o), 1);
        chk("pop_code", 32'(exccode_o), 32'h04);
        chk("pop_inst", inst_o, 0);
      end else begin
        chk("pop_inst", inst_o, mem_word(m_exp_pc));
        chk("pop_exc", 32'(exc_o), 0);
        chk("pop_code", 32'(exccode_o), 0);
        m_exp_pc = m_exp_pc + 32'd4;
      end
    end
    if (!valid_o && ready_i) stall_n++;
    epush = m_err_pend && pend.size() == 0 && !redir;
    keep  = 0;
    if (inst_data_ok) begin
      keep = (pend[0].ep == ep) && !redir;
      void'(pend.pop_front());
    end
    if (inst_req && inst_addr_ok) begin
      pend.push_back('{inst_addr,
                       cyc + int'($urandom_range(lat_min, lat_max)), ep});
      m_fpc = m_fpc + 32'd4;
    end
    if (redir) begin
      ep++;
      m_occ      = 0;
      m_fpc      = rpc;
      m_exp_pc   = rpc;
      m_err_mode = rpc[1:0] != 2'b00;
      m_err_pend = m_err_mode;
      flush_n++;
    end else begin
      m_occ = m_occ + int'(keep) + int'(epush) - int'(pop);
      if (epush) m_err_pend = 0;
    end
    cyc++;
  endtask

  task automatic wait_pop(input string nm);
    int n0 = pop_cnt;
    for (int i = 0; i < 60 && pop_cnt == n0; i++) step(0, 0);
    checks++;
    if (pop_cnt == n0) begin
      errors++;
      $display("FAIL %s: no entry delivered within 60 cycles", nm);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 0;
    redirect_pc    = 0;
    inst_addr_ok   = 0;
    inst_data_ok   = 0;
    inst_rdata     = 0;
    ready_i        = 0;
  endtask

  task automatic check_reset_outs();
    chk("rst_req", 32'(inst_req), 0);
    chk("rst_addr", inst_addr, RST_PC);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_exc", 32'(exc_o), 0);
  endtask

  initial begin
    logic [31:0] r;
    int          n;
    checks = 0; errors = 0; cyc = 0; ep = 0; pop_cnt = 0;
    aok_rand = 0; lat_min = 1; lat_max = 1; rdy_mode = 0;
    idle_inputs();
    resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outs();
    resetn = 1'b1;

    // sequential fetch, one per cycle once warmed up
    wait_pop("first_pop");
    chk("first_pc", lp_pc, 32'hBFC0_0000);
    repeat (6) step(0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      chk("throughput", 32'(valid_o), 1);
    end

    // consumer stalled: queue fills to DEPTH and fetch stops
    rdy_mode = 2;
    repeat (10) step(0, 0);
    chk("full_occ", 32'(m_occ), 4);
    chk("full_req", 32'(inst_req), 0);
    chk("full_valid", 32'(valid_o), 1);
    rdy_mode = 0;
    repeat (20) step(0, 0);

    // redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    n = 0;
    while (pend.size() != 2 && n < 20) begin
      step(0, 0);
      n++;
    end
    chk("two_outstanding", 32'(pend.size()), 2);
    step(1, 32'h8000_0100);
    lat_min = 1; lat_max = 1;
    wait_pop("redir_pop");
    chk("redir_pc", lp_pc, 32'h8000_0100);
    repeat (10) step(0, 0);

    // redirect in the same cycle as a response
    n = 0;
    while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin
      step(0, 0);
      n++;
    end
    step(1, 32'h8000_0200);
    chk("redir_with_dok", 32'(last_dok), 1);
    wait_pop("redir2_pop");
    chk("redir2_pc", lp_pc, 32'h8000_0200);
    repeat (5) step(0, 0);

    // misaligned target: one AdEL entry, no requests
    step(1, 32'h8000_0102);
    wait_pop("adel_pop");
    chk("adel_pc", lp_pc, 32'h8000_0102);
    chk("adel_exc", 32'(lp_exc), 1);
    chk("adel_code", 32'(lp_code), 32'h04);
    repeat (10) step(0, 0);
`ifdef IFQ_PERF_CNT_EN
    chk("perf_flush3", perf_flush_cnt, 3);
`endif

    // randomized traffic
    aok_rand = 1; lat_min = 1; lat_max = 3; rdy_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        r = $urandom();
        if ($urandom_range(0, 5) != 0) r[1:0] = 2'b00;
        step(1, r);
      end else begin
        step(0, 0);
      end
    end
`ifdef IFQ_PERF_CNT_EN
    chk("perf_flush", perf_flush_cnt, 32'(flush_n));
    chk("perf_stall", perf_stall_cnt, 32'(stall_n));
`endif

    // reset in the middle of traffic
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    #1;
    check_reset_outs();
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        r = $urandom();
        r[1:0] = 2'b00;
        step(1, r);
      end else begin
        step(0, 0);
      end
    end
`ifdef IFQ_PERF_CNT_EN
    chk("perf_flush_post", perf_flush_cnt, 32'(flush_n));
    chk("perf_stall_post", perf_stall_cnt, 32'(stall_n));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
